// File: rtl/fir_output_decimator.sv
// rtl/fir_output_decimator.sv - decimate, rescale and queue the 8-tap FIR output
//
// Purpose:
//   Keeps one of every DEC filter samples, arithmetic-shifts it right by SHIFT
//   (optionally rounding half-up), saturates to 16-bit signed and queues it in
//   a DEPTH-entry FIFO that the consumer drains with a valid/ready handshake.
//
// Build option:
//   FIR_DEC_ROUND_EN  defined   -> add 2^(SHIFT-1) before the shift (round half-up)
//                     undefined -> plain arithmetic shift (truncate toward -inf)
//
// Ports:
//   CLK           in   clock, rising edge
//   RST           in   synchronous active-high reset
//   DIN[31:0]     in   signed filter output
//   DIN_VALID     in   DIN carries a new sample this cycle
//   DOUT[15:0]    out  signed word at the FIFO read pointer
//   DOUT_VALID    out  FIFO not empty
//   DOUT_READY    in   consumer takes DOUT when DOUT_VALID && DOUT_READY
//   LEVEL         out  FIFO occupancy, $clog2(DEPTH)+1 bits
//   SAT_FLAG      out  sticky: a kept sample was clipped
//   OVERRUN_FLAG  out  sticky: a kept sample was dropped on a full FIFO
//   FLAG_CLR      in   clears both sticky flags (a same-cycle set wins)

module fir_output_decimator #(
  parameter int DEC   = 4,
  parameter int SHIFT = 7,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                DIN,
  input  logic                       DIN_VALID,
  output logic [15:0]                DOUT,
  output logic                       DOUT_VALID,
  input  logic                       DOUT_READY,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       SAT_FLAG,
  output logic                       OVERRUN_FLAG,
  input  logic                       FLAG_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;

  // Phase counter
  logic [PW-1:0] phase_q, phase_d;
  logic          keep;

  // Stage 1
  logic signed [32:0] din_ext;
  logic signed [32:0] din_rnd;
  logic signed [32:0] din_shr;
  logic               clip_hi, clip_lo;
  logic [15:0]        sat_val;
  logic [15:0]        stg_data_q, stg_data_d;
  logic               stg_valid_q, stg_valid_d;

  // FIFO
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop, push, overrun_evt;

  // Flags
  logic sat_flag_q, sat_flag_d;
  logic overrun_flag_q, overrun_flag_d;

  assign keep = DIN_VALID && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (DIN_VALID) begin
      if (phase_q == PW'(DEC - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Sign-extend to 33 bits so the rounding add can never wrap.
  always_comb begin
    din_ext = {DIN[31], DIN};
`ifdef FIR_DEC_ROUND_EN
    din_rnd = din_ext + (33'sd1 <<< (SHIFT - 1));
`else
    din_rnd = din_ext;
`endif
    din_shr = din_rnd >>> SHIFT;
    clip_hi = (din_shr > 33'sd32767);
    clip_lo = (din_shr < -33'sd32768);
    if (clip_hi) begin
      sat_val = 16'h7FFF;
    end else if (clip_lo) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = din_shr[15:0];
    end
  end

  always_comb begin
    stg_valid_d = keep;
    stg_data_d  = stg_data_q;
    if (keep) begin
      stg_data_d = sat_val;
    end
  end

  // A full FIFO still accepts the stage word when a pop frees a slot on the same edge.
  assign full        = (level_q == LW'(DEPTH));
  assign pop         = (level_q != '0) && DOUT_READY;
  assign push        = stg_valid_q && (!full || pop);
  assign overrun_evt = stg_valid_q && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = stg_data_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Set events take priority over FLAG_CLR.
  always_comb begin
    sat_flag_d     = (FLAG_CLR ? 1'b0 : sat_flag_q) | (keep && (clip_hi || clip_lo));
    overrun_flag_d = (FLAG_CLR ? 1'b0 : overrun_flag_q) | overrun_evt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q        <= '0;
      stg_valid_q    <= 1'b0;
      stg_data_q     <= '0;
      mem_q          <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      level_q        <= '0;
      sat_flag_q     <= 1'b0;
      overrun_flag_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      stg_valid_q    <= stg_valid_d;
      stg_data_q     <= stg_data_d;
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      level_q        <= level_d;
      sat_flag_q     <= sat_flag_d;
      overrun_flag_q <= overrun_flag_d;
    end
  end

  // Storage is cleared on reset, so DOUT reads 0 straight after reset.
  assign DOUT         = mem_q[rd_ptr_q];
  assign DOUT_VALID   = (level_q != '0);
  assign LEVEL        = level_q;
  assign SAT_FLAG     = sat_flag_q;
  assign OVERRUN_FLAG = overrun_flag_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// tb/tb_fir_output_decimator.sv - directed self-checking bench for fir_output_decimator

module tb_fir_output_decimator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] DIN = '0;
  logic        DIN_VALID = 1'b0;
  logic        DOUT_READY = 1'b0;
  logic        FLAG_CLR = 1'b0;

  logic [15:0] dout1, dout4;
  logic        dv1, dv4;
  logic [3:0]  level1, level4;
  logic        sat1, sat4, ovr1, ovr4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  fir_output_decimator #(.DEC(1), .SHIFT(7), .DEPTH(8)) dut1 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DOUT(dout1), .DOUT_VALID(dv1), .DOUT_READY(DOUT_READY),
    .LEVEL(level1), .SAT_FLAG(sat1), .OVERRUN_FLAG(ovr1), .FLAG_CLR(FLAG_CLR)
  );

  fir_output_decimator #(.DEC(4), .SHIFT(7), .DEPTH(8)) dut4 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DOUT(dout4), .DOUT_VALID(dv4), .DOUT_READY(DOUT_READY),
    .LEVEL(level4), .SAT_FLAG(sat4), .OVERRUN_FLAG(ovr4), .FLAG_CLR(FLAG_CLR)
  );

  task automatic apply_reset();
    @(negedge CLK);
    DIN_VALID = 1'b0; FLAG_CLR = 1'b0; DOUT_READY = 1'b0; DIN = '0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    tests_run++;
    if (dout1 !== 16'h0 || dv1 !== 1'b0 || level1 !== 4'd0 || sat1 !== 1'b0 || ovr1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: dout=%h dv=%b level=%0d sat=%b ovr=%b, required all 0", dout1, dv1, level1, sat1, ovr1);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    DOUT_READY = 1'b1;
    DIN = 32'd896; DIN_VALID = 1'b1;
    @(negedge CLK);
    DIN_VALID = 1'b0;
    tests_run++;
    if (dv1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency_early: dv=%b required 0 one cycle after DIN", dv1);
    end
    @(negedge CLK);
    tests_run++;
    if (dv1 !== 1'b1 || dout1 !== 16'd7 || level1 !== 4'd1) begin
      tests_failed++;
      $display("FAIL basic_out: dv=%b dout=%h level=%0d, required 1 0007 1", dv1, dout1, level1);
    end
    @(negedge CLK);
    tests_run++;
    if (dv1 !== 1'b0 || level1 !== 4'd0 || sat1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drain: dv=%b level=%0d sat=%b, required 0 0 0", dv1, level1, sat1);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] exp_pos, exp_neg;
`ifdef FIR_DEC_ROUND_EN
    exp_pos = 16'h0001; exp_neg = 16'h0000;
`else
    exp_pos = 16'h0000; exp_neg = 16'hFFFF;
`endif
    apply_reset();
    DIN = 32'd64; DIN_VALID = 1'b1;
    @(negedge CLK);
    DIN = 32'hFFFF_FFC0;
    @(negedge CLK);
    DIN_VALID = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (level1 !== 4'd2 || dout1 !== exp_pos) begin
      tests_failed++;
      $display("FAIL round_pos: level=%0d dout=%h, required 2 %h", level1, dout1, exp_pos);
    end
    DOUT_READY = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (dout1 !== exp_neg || dv1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL round_neg: dout=%h dv=%b, required %h 1", dout1, dv1, exp_neg);
    end
    @(negedge CLK);
    DOUT_READY = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    DIN = 32'h7FFF_FFFF; DIN_VALID = 1'b1;
    @(negedge CLK);
    DIN_VALID = 1'b0;
    tests_run++;
    if (sat1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_flag_set: sat=%b required 1", sat1);
    end
    @(negedge CLK);
    tests_run++;
    if (dout1 !== 16'h7FFF) begin
      tests_failed++;
      $display("FAIL sat_pos: dout=%h required 7fff", dout1);
    end
    // Clear and a new clip event on the same edge: the flag must stay set.
    DIN = 32'h8000_0000; DIN_VALID = 1'b1; FLAG_CLR = 1'b1;
    @(negedge CLK);
    DIN_VALID = 1'b0; FLAG_CLR = 1'b0;
    tests_run++;
    if (sat1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_set_wins: sat=%b required 1", sat1);
    end
    FLAG_CLR = 1'b1;
    @(negedge CLK);
    FLAG_CLR = 1'b0;
    tests_run++;
    if (sat1 !== 1'b0 || level1 !== 4'd2) begin
      tests_failed++;
      $display("FAIL sat_clear: sat=%b level=%0d, required 0 2", sat1, level1);
    end
    DOUT_READY = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (dout1 !== 16'h8000) begin
      tests_failed++;
      $display("FAIL sat_neg: dout=%h required 8000", dout1);
    end
    @(negedge CLK);
    DOUT_READY = 1'b0;
  endtask

  task automatic test_decimation();
    logic [15:0] got [16];
    int n;
    n = 0;
    apply_reset();
    DOUT_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dv4 === 1'b1 && n < 16) begin
        got[n] = dout4;
        n++;
      end
      if (i < 12) begin
        DIN = 32'(128 * i); DIN_VALID = 1'b1;
      end else begin
        DIN_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL dec_count: outputs=%0d required 3", n);
    end else begin
      for (int j = 0; j < 3; j++) begin
        tests_run++;
        if (got[j] !== 16'(4 * j)) begin
          tests_failed++;
          $display("FAIL dec_value%0d: dout=%h required %h", j, got[j], 16'(4 * j));
        end
      end
    end
    DOUT_READY = 1'b0;
  endtask

  task automatic test_overrun();
    logic [15:0] exp_q [8];
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      DIN = 32'(128 * i); DIN_VALID = 1'b1;
      @(negedge CLK);
    end
    DIN_VALID = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (level1 !== 4'd8 || ovr1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_full: level=%0d ovr=%b, required 8 1", level1, ovr1);
    end
    // Push arrives at the FIFO on the edge where READY pops word 1.
    DIN = 32'd1280; DIN_VALID = 1'b1; FLAG_CLR = 1'b1;
    @(negedge CLK);
    DIN_VALID = 1'b0; FLAG_CLR = 1'b0; DOUT_READY = 1'b1;
    @(negedge CLK);
    DOUT_READY = 1'b0;
    tests_run++;
    if (level1 !== 4'd8 || ovr1 !== 1'b0 || dout1 !== 16'd2) begin
      tests_failed++;
      $display("FAIL full_push_pop: level=%0d ovr=%b dout=%h, required 8 0 0002", level1, ovr1, dout1);
    end
    exp_q = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd10};
    DOUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (dv1 !== 1'b1 || dout1 !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL drain%0d: dv=%b dout=%h, required 1 %h", i, dv1, dout1, exp_q[i]);
      end
      @(negedge CLK);
    end
    tests_run++;
    if (level1 !== 4'd0 || dv1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: level=%0d dv=%b, required 0 0", level1, dv1);
    end
    DOUT_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    DOUT_READY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i <= 5) begin
        tests_run++;
        if (dv1 !== 1'b1 || dout1 !== 16'(10 + i - 2)) begin
          tests_failed++;
          $display("FAIL b2b%0d: dv=%b dout=%h, required 1 %h", i, dv1, dout1, 16'(10 + i - 2));
        end
      end
      if (i < 4) begin
        DIN = 32'(128 * (10 + i)); DIN_VALID = 1'b1;
      end else begin
        DIN_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    tests_run++;
    if (dv1 !== 1'b0 || level1 !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b_end: dv=%b level=%0d, required 0 0", dv1, level1);
    end
    DOUT_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    DIN = 32'h7FFF_FFFF; DIN_VALID = 1'b1;
    @(negedge CLK);
    for (int i = 1; i < 6; i++) begin
      DIN = 32'(128 * i);
      @(negedge CLK);
    end
    DIN_VALID = 1'b0;
    tests_run++;
    if (level1 !== 4'd5 || sat1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_before: level=%0d sat=%b, required 5 1", level1, sat1);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    tests_run++;
    if (dv1 !== 1'b0 || level1 !== 4'd0 || sat1 !== 1'b0 || ovr1 !== 1'b0 || dout1 !== 16'h0 ||
        dv4 !== 1'b0 || level4 !== 4'd0 || sat4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: dv=%b level=%0d sat=%b ovr=%b dout=%h dv4=%b level4=%0d sat4=%b, required all 0",
               dv1, level1, sat1, ovr1, dout1, dv4, level4, sat4);
    end
    @(negedge CLK);
    tests_run++;
    if (level1 !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_inflight: level=%0d required 0", level1);
    end
    DIN = 32'd896; DIN_VALID = 1'b1;
    @(negedge CLK);
    DIN_VALID = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (dv4 !== 1'b1 || dout4 !== 16'd7 || dv1 !== 1'b1 || dout1 !== 16'd7) begin
      tests_failed++;
      $display("FAIL mid_first_kept: dv4=%b dout4=%h dv=%b dout=%h, required 1 0007 1 0007", dv4, dout4, dv1, dout1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_decimation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
